// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI4-Lite response codes, master FSM encoding and helpers
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4,
    ST_RSP     = 3'd5
  } mst_state_e;

  // A channel is finished once its valid has dropped or it handshakes this cycle.
  function automatic logic chan_done(input logic valid, input logic ready);
    return (!valid) || ready;
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// rtl/axi_lite_if.sv - AXI4-Lite AW/W/B/AR/R channel bundle with master/slave views
interface axi_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);

  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - single-outstanding command/response port to AXI4-Lite master bridge
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  axi_lite_if.master            m_axi
);

  // Byte offset inside a data word is dropped: the bus only carries whole words.
  localparam int                    ALIGN_BITS = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK  = {ADDR_WIDTH{1'b1}} << ALIGN_BITS;

  mst_state_e            r_state;
  logic                  r_cmd_ready;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic                  r_awvalid;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic                  r_wvalid;
  logic                  r_bready;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_rsp_valid;
  logic                  r_rsp_write;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [1:0]            r_rsp_resp;

  mst_state_e            w_state_nxt;
  logic                  w_cmd_ready_nxt;
  logic [ADDR_WIDTH-1:0] w_awaddr_nxt;
  logic                  w_awvalid_nxt;
  logic [DATA_WIDTH-1:0] w_wdata_nxt;
  logic [STRB_WIDTH-1:0] w_wstrb_nxt;
  logic                  w_wvalid_nxt;
  logic                  w_bready_nxt;
  logic [ADDR_WIDTH-1:0] w_araddr_nxt;
  logic                  w_arvalid_nxt;
  logic                  w_rready_nxt;
  logic                  w_rsp_valid_nxt;
  logic                  w_rsp_write_nxt;
  logic [DATA_WIDTH-1:0] w_rsp_rdata_nxt;
  logic [1:0]            w_rsp_resp_nxt;

  logic [ADDR_WIDTH-1:0] w_addr_aligned;
  logic                  w_aw_fin;
  logic                  w_w_fin;

  assign w_addr_aligned = cmd_addr & ADDR_MASK;
  assign w_aw_fin       = chan_done(r_awvalid, m_axi.awready);
  assign w_w_fin        = chan_done(r_wvalid, m_axi.wready);

  // State and payload registers; reset abandons any in-flight transaction.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_awaddr    <= '0;
      r_awvalid   <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_araddr    <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= RESP_OKAY;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_awaddr    <= w_awaddr_nxt;
      r_awvalid   <= w_awvalid_nxt;
      r_wdata     <= w_wdata_nxt;
      r_wstrb     <= w_wstrb_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_bready    <= w_bready_nxt;
      r_araddr    <= w_araddr_nxt;
      r_arvalid   <= w_arvalid_nxt;
      r_rready    <= w_rready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_write <= w_rsp_write_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_resp  <= w_rsp_resp_nxt;
    end
  end

  // Next-state and next-output logic; every bus output is registered so no
  // valid ever depends combinationally on its ready.
  always_comb begin
    w_state_nxt     = r_state;
    w_cmd_ready_nxt = r_cmd_ready;
    w_awaddr_nxt    = r_awaddr;
    w_awvalid_nxt   = r_awvalid;
    w_wdata_nxt     = r_wdata;
    w_wstrb_nxt     = r_wstrb;
    w_wvalid_nxt    = r_wvalid;
    w_bready_nxt    = r_bready;
    w_araddr_nxt    = r_araddr;
    w_arvalid_nxt   = r_arvalid;
    w_rready_nxt    = r_rready;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_write_nxt = r_rsp_write;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_resp_nxt  = r_rsp_resp;

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_cmd_ready_nxt = 1'b0;
          if (cmd_write) begin
            w_awaddr_nxt  = w_addr_aligned;
            w_awvalid_nxt = 1'b1;
            w_wdata_nxt   = cmd_wdata;
            w_wstrb_nxt   = cmd_wstrb;
            w_wvalid_nxt  = 1'b1;
            w_state_nxt   = ST_WR_REQ;
          end else begin
            w_araddr_nxt  = w_addr_aligned;
            w_arvalid_nxt = 1'b1;
            w_state_nxt   = ST_RD_REQ;
          end
        end else begin
          // Covers the first cycle after reset release.
          w_cmd_ready_nxt = 1'b1;
        end
      end

      ST_WR_REQ: begin
        // AW and W complete independently, in either order or together.
        if (r_awvalid && m_axi.awready) w_awvalid_nxt = 1'b0;
        if (r_wvalid && m_axi.wready)   w_wvalid_nxt  = 1'b0;
        if (w_aw_fin && w_w_fin) begin
          w_bready_nxt = 1'b1;
          w_state_nxt  = ST_WR_RESP;
        end
      end

      ST_WR_RESP: begin
        if (m_axi.bvalid && r_bready) begin
          w_bready_nxt    = 1'b0;
          w_rsp_resp_nxt  = m_axi.bresp;
          w_rsp_write_nxt = 1'b1;
          w_rsp_rdata_nxt = '0;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = ST_RSP;
        end
      end

      ST_RD_REQ: begin
        if (r_arvalid && m_axi.arready) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = ST_RD_RESP;
        end
      end

      ST_RD_RESP: begin
        if (m_axi.rvalid && r_rready) begin
          w_rready_nxt    = 1'b0;
          w_rsp_rdata_nxt = m_axi.rdata;
          w_rsp_resp_nxt  = m_axi.rresp;
          w_rsp_write_nxt = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = ST_RSP;
        end
      end

      ST_RSP: begin
        // Response payload is held until the consumer takes it.
        if (r_rsp_valid && rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_cmd_ready_nxt = 1'b1;
          w_state_nxt     = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_write     = r_rsp_write;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;

  assign m_axi.awaddr  = r_awaddr;
  assign m_axi.awvalid = r_awvalid;
  assign m_axi.wdata   = r_wdata;
  assign m_axi.wstrb   = r_wstrb;
  assign m_axi.wvalid  = r_wvalid;
  assign m_axi.bready  = r_bready;
  assign m_axi.araddr  = r_araddr;
  assign m_axi.arvalid = r_arvalid;
  assign m_axi.rready  = r_rready;

endmodule
